// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - 32-bit load/store front end for an 8-bit-wide RAM
//
// Purpose:
//   Accepts one word-wide load or store at a time and serialises it into
//   byte accesses, one selected lane per cycle in ascending lane order.
//   Loads reassemble the returned bytes into a 32-bit result with
//   unselected lanes zeroed.
//
// Ports:
//   clk, rst        single clock, asynchronous active-high reset
//   mem_req_i       request strobe, honoured only while mem_ready_o=1
//   mem_we_i        1 = store, 0 = load
//   mem_addr_i      byte address of lane 0
//   mem_data_i      store data, lane k = bits [8k+7:8k]
//   mem_sel_i       lane enable mask
//   mem_ready_o     idle, a request on this edge will be taken
//   mem_valid_o     one-cycle completion pulse
//   mem_data_o      assembled load data, held until the next load completes
//   ram_addr_o      byte address to the RAM (low ADDR_WIDTH bits)
//   ram_dout_o      byte written to the RAM
//   ram_we_o        RAM write strobe
//   ram_din_i       RAM read byte, one cycle after its address

module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [31:0]           mem_addr_i,
  input  logic [31:0]           mem_data_i,
  input  logic [3:0]            mem_sel_i,
  output logic                  mem_ready_o,
  output logic                  mem_valid_o,
  output logic [31:0]           mem_data_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [7:0]            ram_dout_o,
  output logic                  ram_we_o,
  input  logic [7:0]            ram_din_i
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_sel;
  logic [1:0]  r_lane;      // lane being addressed this cycle
  logic        r_drain;     // RD: all addresses issued, waiting for the last byte
  logic        r_cap_vld;   // ram_din_i carries a byte for r_cap_lane this cycle
  logic [1:0]  r_cap_lane;
  logic [31:0] r_acc;       // partial load result being assembled
  logic [31:0] r_rdata;     // last completed load result

  logic [2:0]  w_first;     // {found, lane}
  logic [2:0]  w_next;
  logic [31:0] w_lane_addr;
  logic [31:0] w_acc_next;
  logic        w_addr_phase;

  // Lowest set lane of sel, either overall or strictly above cur.
  function automatic logic [2:0] f_find_lane(input logic [3:0] sel,
                                             input logic [1:0] cur,
                                             input logic       from_start);
    logic [2:0] res;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      if (sel[k] && (from_start || (2'(k) > cur))) begin
        res = {1'b1, 2'(k)};
      end
    end
    return res;
  endfunction

  assign w_first     = f_find_lane(mem_sel_i, 2'd0, 1'b1);
  assign w_next      = f_find_lane(r_sel, r_lane, 1'b0);
  // 32-bit add so lane addresses wrap modulo 2^32 before truncation.
  assign w_lane_addr = r_addr + {30'd0, r_lane};

  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[{r_cap_lane, 3'b000} +: 8] = ram_din_i;
  end

  assign w_addr_phase = (r_state == S_WR) || ((r_state == S_RD) && !r_drain);

  // Outputs are decoded from reset-cleared state so reset takes effect
  // immediately without waiting for a clock edge.
  assign mem_ready_o = (r_state == S_IDLE);
  assign mem_valid_o = (r_state == S_DONE);
  assign mem_data_o  = r_rdata;
  assign ram_we_o    = (r_state == S_WR);
  assign ram_addr_o  = w_addr_phase ? w_lane_addr[ADDR_WIDTH-1:0] : '0;
  assign ram_dout_o  = (r_state == S_WR) ? r_wdata[{r_lane, 3'b000} +: 8] : 8'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_sel      <= 4'd0;
      r_lane     <= 2'd0;
      r_drain    <= 1'b0;
      r_cap_vld  <= 1'b0;
      r_cap_lane <= 2'd0;
      r_acc      <= 32'd0;
      r_rdata    <= 32'd0;
    end else begin
      r_cap_vld <= 1'b0;
      if (r_cap_vld) begin
        r_acc <= w_acc_next;
      end

      case (r_state)
        S_IDLE: begin
          if (mem_req_i) begin
            r_addr  <= mem_addr_i;
            r_wdata <= mem_data_i;
            r_sel   <= mem_sel_i;
            r_lane  <= w_first[1:0];
            r_drain <= 1'b0;
            r_acc   <= 32'd0;
            if (mem_sel_i == 4'b0000) begin
              r_state <= S_DONE;
              r_rdata <= 32'd0;
            end else if (mem_we_i) begin
              r_state <= S_WR;
            end else begin
              r_state <= S_RD;
            end
          end
        end

        S_WR: begin
          if (w_next[2]) begin
            r_lane <= w_next[1:0];
          end else begin
            r_state <= S_DONE;
          end
        end

        S_RD: begin
          if (!r_drain) begin
            // Byte for this address arrives next cycle; remember its lane.
            r_cap_vld  <= 1'b1;
            r_cap_lane <= r_lane;
            if (w_next[2]) begin
              r_lane <= w_next[1:0];
            end else begin
              r_drain <= 1'b1;
            end
          end else begin
            // Last byte is on ram_din_i now; publish the full word.
            r_rdata <= w_acc_next;
            r_state <= S_DONE;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed scoreboard bench for data_mem_ctrl

module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_data_i;
  logic [3:0]  mem_sel_i;
  logic        mem_ready_o;
  logic        mem_valid_o;
  logic [31:0] mem_data_o;
  logic [31:0] ram_addr_o;
  logic [7:0]  ram_dout_o;
  logic        ram_we_o;
  logic [7:0]  ram_din_i = 8'h00;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ram   [logic [31:0]];
  logic [7:0]  model [logic [31:0]];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd = 32'd0;

  data_mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req_i   (mem_req_i),
    .mem_we_i    (mem_we_i),
    .mem_addr_i  (mem_addr_i),
    .mem_data_i  (mem_data_i),
    .mem_sel_i   (mem_sel_i),
    .mem_ready_o (mem_ready_o),
    .mem_valid_o (mem_valid_o),
    .mem_data_o  (mem_data_o),
    .ram_addr_o  (ram_addr_o),
    .ram_dout_o  (ram_dout_o),
    .ram_we_o    (ram_we_o),
    .ram_din_i   (ram_din_i)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    if (ram.exists(ram_addr_o)) ram_din_i <= ram[ram_addr_o];
    else                        ram_din_i <= 8'h00;
    if (ram_we_o) ram[ram_addr_o] = ram_dout_o;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [3:0] s);
    logic [31:0] r;
    r = 32'd0;
    for (int k = 0; k < 4; k++) begin
      if (s[k] && model.exists(a + 32'(k))) r[8*k +: 8] = model[a + 32'(k)];
    end
    return r;
  endfunction

  // One transaction with a cycle-by-cycle expected schedule. If hold=1 the
  // request stays high after acceptance with a sel=0000 load behind it.
  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] sel, input logic hold);
    int    lanes [4];
    int    n;
    int    lat;
    bit    acc;
    n = 0;
    for (int k = 0; k < 4; k++) if (sel[k]) begin lanes[n] = k; n++; end
    lat = (n == 0) ? 0 : (we ? n : n + 1);

    if (n == 0) last_rd = 32'd0;
    else if (we) begin
      for (int i = 0; i < n; i++) model[addr + 32'(lanes[i])] = data[8*lanes[i] +: 8];
    end else last_rd = model_load(addr, sel);
    exp_q.push_back(last_rd);

    @(negedge clk);
    mem_req_i  = 1'b1;
    mem_we_i   = we;
    mem_addr_i = addr;
    mem_data_i = data;
    mem_sel_i  = sel;
    acc = 1'b0;
    for (int t = 0; t < 40 && !acc; t++) begin
      if (mem_ready_o) acc = 1'b1;
      else @(negedge clk);
    end
    check({name, " accept"}, 32'(acc), 32'd1);
    if (!acc) begin
      mem_req_i = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge clk);
    #1;
    if (hold) begin
      mem_we_i   = 1'b0;
      mem_sel_i  = 4'b0000;
      mem_data_i = 32'd0;
    end else begin
      mem_req_i = 1'b0;
    end

    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      check($sformatf("%s c%0d we", name, c), 32'(ram_we_o), 32'(we && (c < n)));
      check($sformatf("%s c%0d valid", name, c), 32'(mem_valid_o), 32'(c == lat));
      check($sformatf("%s c%0d ready", name, c), 32'(mem_ready_o), 32'd0);
      if (c < n) begin
        check($sformatf("%s c%0d addr", name, c), ram_addr_o, addr + 32'(lanes[c]));
        if (we) check($sformatf("%s c%0d dout", name, c), 32'(ram_dout_o), 32'(data[8*lanes[c] +: 8]));
      end
      if (c == lat) begin
        check({name, " done addr"}, ram_addr_o, 32'd0);
        check({name, " done dout"}, 32'(ram_dout_o), 32'd0);
        check({name, " data"}, mem_data_o, exp_q.pop_front());
      end
    end
    @(negedge clk);
    check({name, " idle ready"}, 32'(mem_ready_o), 32'd1);
    check({name, " idle valid"}, 32'(mem_valid_o), 32'd0);
    check({name, " idle we"}, 32'(ram_we_o), 32'd0);
    check({name, " idle addr"}, ram_addr_o, 32'd0);
  endtask

  initial begin
    rst = 1'b1; mem_req_i = 1'b0; mem_we_i = 1'b0;
    mem_addr_i = 32'd0; mem_data_i = 32'd0; mem_sel_i = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", 32'(mem_ready_o), 32'd1);
    check("rst valid", 32'(mem_valid_o), 32'd0);
    check("rst data", mem_data_o, 32'd0);
    check("rst addr", ram_addr_o, 32'd0);
    check("rst dout", 32'(ram_dout_o), 32'd0);
    check("rst we", 32'(ram_we_o), 32'd0);
    rst = 1'b0;

    // Word load of 11,22,33,44 at 0x100
    do_req("pre100", 1'b1, 32'h100, 32'h44332211, 4'b1111, 1'b0);
    do_req("wload", 1'b0, 32'h100, 32'h0, 4'b1111, 1'b0);
    check("wload const", mem_data_o, 32'h44332211);

    // Half store, then load data must still be held
    do_req("hstore", 1'b1, 32'h200, 32'hAABBCCDD, 4'b1100, 1'b0);
    check("hold after store", mem_data_o, 32'h44332211);
    do_req("hload", 1'b0, 32'h200, 32'h0, 4'b1111, 1'b0);
    check("hload const", mem_data_o, 32'hAABB0000);

    // Byte load across the top of the address space
    do_req("preFFF", 1'b1, 32'hFFFFFFFC, 32'h7F000000, 4'b1000, 1'b0);
    do_req("wrapld", 1'b0, 32'hFFFFFFFE, 32'h0, 4'b0010, 1'b0);
    check("wrapld const", mem_data_o, 32'h00007F00);

    // Sparse load with a held sel=0000 request queued behind it
    do_req("pre300", 1'b1, 32'h300, 32'h12345678, 4'b1111, 1'b0);
    do_req("sparse", 1'b0, 32'h300, 32'h0, 4'b0101, 1'b1);
    check("sparse const", mem_data_o, 32'h00340078);
    @(posedge clk);
    #1 mem_req_i = 1'b0;
    @(negedge clk);
    check("sel0 valid", 32'(mem_valid_o), 32'd1);
    check("sel0 data", mem_data_o, 32'd0);
    check("sel0 we", 32'(ram_we_o), 32'd0);
    last_rd = 32'd0;
    @(negedge clk);
    check("sel0 ready", 32'(mem_ready_o), 32'd1);
    check("sel0 valid off", 32'(mem_valid_o), 32'd0);

    // Mixed traffic in a small window
    for (int i = 0; i < 8; i++) begin
      do_req($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 32'h400 + 32'($urandom_range(0, 12)),
             $urandom, 4'($urandom_range(0, 15)), 1'b0);
    end

    // Reset in cycle 1 of a word store
    @(negedge clk);
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h500;
    mem_data_i = 32'hCAFEF00D; mem_sel_i = 4'b1111;
    check("rmid ready", 32'(mem_ready_o), 32'd1);
    @(posedge clk);
    #1 mem_req_i = 1'b0;
    @(posedge clk);
    #2;
    check("rmid c1 we", 32'(ram_we_o), 32'd1);
    check("rmid c1 addr", ram_addr_o, 32'h501);
    rst = 1'b1;
    #1;
    check("rmid we", 32'(ram_we_o), 32'd0);
    check("rmid ready", 32'(mem_ready_o), 32'd1);
    check("rmid valid", 32'(mem_valid_o), 32'd0);
    check("rmid addr", ram_addr_o, 32'd0);
    model[32'h500] = 8'h0D;
    last_rd = 32'd0;
    repeat (2) begin
      @(negedge clk);
      check("rmid no valid", 32'(mem_valid_o), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("rmid post valid", 32'(mem_valid_o), 32'd0);
    do_req("postrst", 1'b0, 32'h500, 32'h0, 4'b1111, 1'b0);
    check("postrst const", mem_data_o, 32'h0000000D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
